// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment glyphs, anode one-hot codes, scan FSM states.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package seg7_pkg;

  // Active-low 7-bit glyphs, bit order g..a.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Active-low anode codes; exactly one digit enabled, or none.
  localparam logic [3:0] AN_DIG0  = 4'b1110;
  localparam logic [3:0] AN_DIG1  = 4'b1101;
  localparam logic [3:0] AN_DIG2  = 4'b1011;
  localparam logic [3:0] AN_DIG3  = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  // Nibble to glyph, for the driver side.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_encode = SEG_0;
      4'h1: seg_encode = SEG_1;
      4'h2: seg_encode = SEG_2;
      4'h3: seg_encode = SEG_3;
      4'h4: seg_encode = SEG_4;
      4'h5: seg_encode = SEG_5;
      4'h6: seg_encode = SEG_6;
      4'h7: seg_encode = SEG_7;
      4'h8: seg_encode = SEG_8;
      4'h9: seg_encode = SEG_9;
      4'hA: seg_encode = SEG_A;
      4'hB: seg_encode = SEG_B;
      4'hC: seg_encode = SEG_C;
      4'hD: seg_encode = SEG_D;
      4'hE: seg_encode = SEG_E;
      default: seg_encode = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Seven-segment glyph to hex nibble decoder; flags patterns that are not a hex glyph.
// Latency: combinational.
// Backpressure: none.
// Ports: pattern[6:0] active-low g..a in; valid, nibble[3:0] out.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    case (pattern)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Sniffs a scanned 4-digit seven-segment display and rebuilds the shown hex value and dps.
// Latency: 2 sync cycles + SETTLE_CYCLES-1 to capture a digit; frame pulses the cycle after all 4 seen.
// Backpressure: none; passive monitor, frames are presented as one-cycle pulses.
// Ports: mclk, rst (sync, high); an_n[3:0], seg_n[7:0] async in;
//        value[15:0], dp[3:0], frame_valid, seg_err, an_err, stale out.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [3:0]  an_n,
  input  logic [7:0]  seg_n,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        an_err,
  output logic        stale
);

  // Extra headroom so cnt+1 never wraps, even with SETTLE_CYCLES = 1.
  localparam int CW = $clog2(SETTLE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_TGT  = CW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_TGT = TW'(TIMEOUT_CYCLES);

  logic [3:0]  an_m, an_s;
  logic [7:0]  seg_m, seg_s;
  logic [11:0] cur, prev, held;
  logic        stable, changed;
  logic        an_legal, an_multi;
  logic [1:0]  an_dig, cap_dig;
  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_plus;
  logic        cnt_load, cnt_inc, held_load, cap_en;
  logic        pat_valid;
  logic [3:0]  pat_nib;
  logic [15:0] shadow_val;
  logic [3:0]  shadow_dp, seen, seen_nxt;
  logic        frame_done;
  logic [TW-1:0] tcnt;

  always_ff @(posedge mclk) begin
    if (rst) begin
      an_m  <= '1;
      an_s  <= '1;
      seg_m <= '1;
      seg_s <= '1;
      prev  <= '1;
    end else begin
      an_m  <= an_n;
      an_s  <= an_m;
      seg_m <= seg_n;
      seg_s <= seg_m;
      prev  <= cur;
    end
  end

  assign cur      = {an_s, seg_s};
  assign stable   = (cur == prev);
  // HOLD compares against the captured sample, not last cycle, so a change
  // landing on the CAPTURE cycle itself is still noticed.
  assign changed  = (cur != held);
  assign cnt_plus = cnt + CW'(1);

  always_comb begin
    an_legal = 1'b1;
    an_dig   = 2'd0;
    case (an_s)
      AN_DIG0: an_dig = 2'd0;
      AN_DIG1: an_dig = 2'd1;
      AN_DIG2: an_dig = 2'd2;
      AN_DIG3: an_dig = 2'd3;
      default: an_legal = 1'b0;
    endcase
  end

  assign an_multi = !an_legal && (an_s != AN_BLANK);

  // FSM: state register
  always_ff @(posedge mclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (an_legal) state_nxt = SETTLE;
      SETTLE: begin
        if (stable) begin
          if (cnt_plus >= SETTLE_TGT) state_nxt = CAPTURE;
        end else if (!an_legal) begin
          state_nxt = IDLE;
        end
      end
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (changed) state_nxt = an_legal ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    held_load = 1'b0;
    cap_en    = 1'b0;
    case (state)
      IDLE:    cnt_load = an_legal;
      SETTLE: begin
        cnt_inc   = stable;
        cnt_load  = !stable && an_legal;
        held_load = stable && (cnt_plus >= SETTLE_TGT);
      end
      CAPTURE: cap_en = 1'b1;
      HOLD:    cnt_load = changed && an_legal;
      default: ;
    endcase
  end

  seg7_pattern_decode u_decode (
    .pattern (held[6:0]),
    .valid   (pat_valid),
    .nibble  (pat_nib)
  );

  // Completed frame clears seen, but a digit captured on the same edge survives.
  assign frame_done = (seen == 4'b1111);
  always_comb begin
    seen_nxt = frame_done ? 4'b0000 : seen;
    if (cap_en && pat_valid) seen_nxt = seen_nxt | (4'b0001 << cap_dig);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt         <= '0;
      held        <= '1;
      cap_dig     <= 2'd0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      seen        <= '0;
      value       <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      an_err      <= 1'b0;
      tcnt        <= '0;
    end else begin
      if (cnt_load)     cnt <= CW'(1);
      else if (cnt_inc) cnt <= cnt_plus;

      if (held_load) begin
        held    <= cur;
        cap_dig <= an_dig;
      end

      if (cap_en && pat_valid) begin
        shadow_val[{cap_dig, 2'b00} +: 4] <= pat_nib;
        shadow_dp[cap_dig]                <= ~held[7];
      end

      seen        <= seen_nxt;
      frame_valid <= frame_done;
      if (frame_done) begin
        value <= shadow_val;
        dp    <= shadow_dp;
      end

      if (cap_en && !pat_valid) seg_err <= 1'b1;
      if (an_multi)             an_err  <= 1'b1;

      if (frame_valid)               tcnt <= '0;
      else if (tcnt != TIMEOUT_TGT)  tcnt <= tcnt + TW'(1);
    end
  end

  assign stale = (tcnt == TIMEOUT_TGT);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  logic        mclk = 1'b0;
  logic        rst;
  logic [3:0]  an_n;
  logic [7:0]  seg_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        frame_valid, seg_err, an_err, stale;

  int checks   = 0;
  int failures = 0;
  int frames   = 0;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  d;
  } exp_t;
  exp_t sb[$];

  seg7_scan_decoder #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(200)) dut (
    .mclk        (mclk),
    .rst         (rst),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .value       (value),
    .dp          (dp),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .an_err      (an_err),
    .stale       (stale)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;  4'h9: enc = 7'h10;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  default: enc = 7'h0E;
    endcase
  endfunction

  // Inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic drive_raw(input logic [3:0] a, input logic [7:0] s, input int cyc);
    an_n  = a;
    seg_n = s;
    tick(cyc);
  endtask

  task automatic drive_digit(input int k, input logic [3:0] nib, input logic dpb, input int cyc);
    logic [3:0] one;
    one = 4'b0001 << k;
    drive_raw(~one, {~dpb, enc(nib)}, cyc);
  endtask

  task automatic scan_range(input logic [15:0] v, input logic [3:0] d,
                            input int first, input int last, input int hold);
    for (int k = first; k <= last; k++) drive_digit(k, v[4*k +: 4], d[k], hold);
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] d, input int hold);
    exp_t e;
    e.v = v;
    e.d = d;
    sb.push_back(e);
    scan_range(v, d, 0, 3, hold);
    drive_raw(4'hF, 8'hFF, 10);
  endtask

  // Scoreboard consumer.
  always @(negedge mclk) begin
    if (frame_valid) begin
      exp_t e;
      frames++;
      if (sb.size() == 0) begin
        check("unexpected_frame", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("frame_value", value, e.v);
        check("frame_dp", dp, e.d);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    exp_t e;
    rst   = 1'b1;
    an_n  = 4'hF;
    seg_n = 8'hFF;
    tick(3);
    check("rst_value", value, 0);
    check("rst_dp", dp, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_seg_err", seg_err, 0);
    check("rst_an_err", an_err, 0);
    check("rst_stale", stale, 0);
    rst = 1'b0;
    tick(5);

    // Plain 1234 scan, exactly one frame.
    f0 = frames;
    scan(16'h1234, 4'b0000, 40);
    check("scan1234_drained", sb.size(), 0);
    check("scan1234_frames", frames - f0, 1);
    check("scan1234_seg_err", seg_err, 0);

    // Decimal point on digit2 only.
    scan(16'h5A0F, 4'b0100, 40);
    check("dp_scan_drained", sb.size(), 0);

    // Short glitch on digit1 must not be captured.
    e.v = 16'h0123;
    e.d = 4'b0000;
    sb.push_back(e);
    drive_digit(0, 4'h3, 1'b0, 40);
    drive_digit(1, 4'h2, 1'b0, 10);
    drive_raw(4'b1101, 8'hFF, 5);
    drive_digit(1, 4'h2, 1'b0, 45);
    scan_range(16'h0123, 4'b0000, 2, 3, 40);
    drive_raw(4'hF, 8'hFF, 10);
    check("glitch_drained", sb.size(), 0);
    check("glitch_seg_err", seg_err, 0);
    check("glitch_an_err", an_err, 0);

    // Undecodable glyph held on digit3: sticky seg_err, frame waits for a legal glyph.
    f0 = frames;
    scan_range(16'h0987, 4'b0000, 0, 2, 40);
    drive_raw(4'b0111, 8'hFF, 40);
    check("bad_glyph_seg_err", seg_err, 1);
    check("bad_glyph_no_frame", frames - f0, 0);
    e.v = 16'hC987;
    e.d = 4'b0000;
    sb.push_back(e);
    drive_digit(3, 4'hC, 1'b0, 40);
    drive_raw(4'hF, 8'hFF, 10);
    check("bad_glyph_drained", sb.size(), 0);
    check("seg_err_sticky", seg_err, 1);

    // Two anodes low.
    f0 = frames;
    drive_raw(4'b1100, {1'b1, enc(4'h8)}, 30);
    drive_raw(4'hF, 8'hFF, 5);
    check("an_err_set", an_err, 1);
    check("an_err_no_frame", frames - f0, 0);
    scan(16'hBEAD, 4'b0000, 40);
    check("an_err_scan_drained", sb.size(), 0);

    // Reset clears sticky flags; timeout boundary at 200 cycles.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst2_seg_err", seg_err, 0);
    check("rst2_an_err", an_err, 0);
    check("rst2_value", value, 0);
    tick(199);
    check("stale_at_199", stale, 0);
    tick(1);
    check("stale_at_200", stale, 1);
    tick(50);
    check("stale_held", stale, 1);
    scan(16'h4321, 4'b1000, 40);
    check("stale_scan_drained", sb.size(), 0);
    check("stale_cleared", stale, 0);

    // Reset mid-scan discards partially seen digits.
    drive_digit(0, 4'h6, 1'b0, 40);
    drive_digit(1, 4'h7, 1'b0, 40);
    rst   = 1'b1;
    an_n  = 4'hF;
    seg_n = 8'hFF;
    tick(1);
    rst = 1'b0;
    check("midrst_value", value, 0);
    check("midrst_dp", dp, 0);
    check("midrst_frame_valid", frame_valid, 0);
    check("midrst_stale", stale, 0);
    f0 = frames;
    scan_range(16'h9800, 4'b0000, 2, 3, 40);
    drive_raw(4'hF, 8'hFF, 60);
    check("midrst_no_frame", frames - f0, 0);
    e.v = 16'h9876;
    e.d = 4'b0000;
    sb.push_back(e);
    scan_range(16'h9876, 4'b0000, 0, 1, 40);
    drive_raw(4'hF, 8'hFF, 10);
    check("midrst_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the 4-digit multiplexed seven-segment driver. Samples the scanned active-low anode and segment lines and reconstructs the displayed 16-bit hex value plus decimal points, one frame at a time. Used as a board-to-board display sniffer and as a self-check monitor on the display drivers. Flags illegal segment patterns, illegal anode codes and a stalled scan.

Parameters:
SETTLE_CYCLES, 16, consecutive stable synchronized cycles required before a digit is captured (min 1)
TIMEOUT_CYCLES, 1000000, cycles without a completed frame before stale asserts

Ports:
mclk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-high
an_n  input  4  scanned anodes, active-low, asynchronous to mclk
seg_n  input  8  segments, active-low; bit7 = dp, bits6:0 = g..a
value  output  16  last complete frame; digit k in [4k+3:4k]
dp  output  4  last complete frame decimal points, 1 = lit
frame_valid  output  1  one-cycle pulse when value/dp update
seg_err  output  1  sticky: undecodable pattern captured
an_err  output  1  sticky: more than one anode low
stale  output  1  no frame completed within TIMEOUT_CYCLES

Behaviour:
- Reset: value=0, dp=0, frame_valid=0, seg_err=0, an_err=0, stale=0; synchronizers set to 1s, seen=0, counters=0, FSM in IDLE.
- an_n and seg_n pass through a 2-flop synchronizer (reset value all 1s); all logic below uses the synced values (an_s, seg_s).
- Anode decode: 1110->digit0, 1101->1, 1011->2, 0111->3. 1111 = blank (no digit). Any code with two or more zeros sets an_err and is treated as blank.
- Segment decode on seg_s[6:0]: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,B=03,C=46,D=21,E=06,F=0E (hex, 7-bit). dp bit = ~seg_s[7]. Any other pattern is invalid.
- FSM states:
  IDLE: wait for a legal one-hot anode. Then load the settle counter with 1 and go to SETTLE.
  SETTLE: if {an_s,seg_s} equals the previous cycle's value, increment the counter; else if the anode is still legal, restart at 1; else go to IDLE. When the counter reaches SETTLE_CYCLES, go to CAPTURE.
  CAPTURE (1 cycle): on a valid pattern, write the nibble and dp into shadow[digit] and set seen[digit]. On an invalid pattern, set seg_err; shadow and seen are unchanged. Go to HOLD.
  HOLD: remain while {an_s,seg_s} is unchanged. On any change, go to SETTLE with the counter at 1 if the anode is legal, else go to IDLE.
- Frame completion: the cycle after seen becomes 4'b1111, value/dp load from shadow, frame_valid=1 for exactly that cycle, and seen clears. A digit recaptured before frame completion overwrites its shadow entry.
- Capture latency: first settled sample to CAPTURE = SETTLE_CYCLES-1 cycles, plus 2 synchronizer cycles.
- Timeout counter: clears on frame_valid and saturates at TIMEOUT_CYCLES. stale=1 while saturated; it clears on the next frame_valid.
- seg_err and an_err clear only on rst.
- rst mid-operation: everything returns to reset values next cycle, including partially seen frames.
- rst has priority over all other events. frame_valid and CAPTURE in the same cycle is legal: the seen clear wins for bits not newly set; a newly captured digit's seen bit is kept.

Decomposition:
- Package seg7_pkg: 16 segment pattern constants, the 4 anode one-hot codes, the BLANK code (4'b1111), and FSM state typedef {IDLE, SETTLE, CAPTURE, HOLD}. The package is shared with the driver side.
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern -> {valid, nibble[3:0]}.
- Synchronizer, FSM, shadow/seen registers and timeout counter stay in the top level.

Test Plan:
- Scan 1234 (each anode held 40 cycles, SETTLE_CYCLES=16, order digit0..3) -> exactly one frame_valid; value=16'h1234, dp=0, seg_err=0.
- Same scan with seg_n[7]=0 on digit2 only, digits 0..3 = F,0,A,5 -> value=16'h5A0F, dp=4'b0100.
- Segment glitch: digit1 shows 0x24, toggles to 0x7F for 5 cycles, returns to 0x24 -> no seg_err; after the frame, value[7:4]=2.
- Hold pattern 7'h7F stably on digit3 -> seg_err=1 (sticky), no frame_valid until digit3 later shows a legal pattern.
- Drive an_n=4'b1100 for 30 cycles -> an_err=1 and no capture; the subsequent legal scan still completes a frame.
- TIMEOUT_CYCLES=200 with anodes all 1111 for 250 cycles -> stale=1 at cycle 200. A full scan then gives frame_valid and stale=0. Assert rst mid-scan -> next cycle all outputs are 0 and seen is cleared.
